// File: rtl/axis_iir_inv8_v1_0.sv
// axis_iir_inv8_v1_0
// Serial 8th-order all-pole IIR on AXI-Stream: y[n] = x[n] - sum(k=1..8) a_k*y[n-k].
// One shared MAC evaluates one tap per cycle; the block accepts one sample every
// 11 cycles and holds its result until the downstream side takes it.
// Optional feature macro: AXIS_IIR_INV8_SAT_EN (saturating narrowing of y; wraps if undefined).
module axis_iir_inv8_v1_0 #(
  parameter int inout_width               = 16,
  parameter int inout_decimal_width       = 15,
  parameter int coefficient_width         = 16,
  parameter int coefficient_decimal_width = 14,
  parameter int acc_width                 = 40
) (
  input  logic                                aclk,
  input  logic                                resetn,
  input  logic [inout_width-1:0]              s_axis_tdata,
  input  logic                                s_axis_tlast,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  output logic [inout_width-1:0]              m_axis_tdata,
  output logic                                m_axis_tlast,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  input  logic signed [coefficient_width-1:0] a1,
  input  logic signed [coefficient_width-1:0] a2,
  input  logic signed [coefficient_width-1:0] a3,
  input  logic signed [coefficient_width-1:0] a4,
  input  logic signed [coefficient_width-1:0] a5,
  input  logic signed [coefficient_width-1:0] a6,
  input  logic signed [coefficient_width-1:0] a7,
  input  logic signed [coefficient_width-1:0] a8
);

  localparam int iw  = inout_width;
  localparam int cw  = coefficient_width;
  localparam int cdw = coefficient_decimal_width;

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_RESULT, ST_OUT} state_e;

  state_e                   state_q, state_d;
  logic signed [acc_width-1:0] acc_q, acc_d;
  logic [3:0]               index_q, index_d;
  // Element k-1 holds a_k / y[n-k].
  logic signed [cw-1:0]     a_sh_q [0:7];
  logic signed [cw-1:0]     a_sh_d [0:7];
  logic signed [iw-1:0]     y_hist_q [0:7];
  logic signed [iw-1:0]     y_hist_d [0:7];
  logic                     last_q, last_d;
  logic [iw-1:0]            m_tdata_q, m_tdata_d;
  logic                     m_tlast_q, m_tlast_d;
  logic                     m_tvalid_q, m_tvalid_d;

  logic [2:0]               tap;
  logic signed [iw+cw-1:0]  prod;
  logic [acc_width-1:0]     prod_ext;
  logic [acc_width-1:0]     x_ext;
  logic [iw-1:0]            y_narrow;

  assign s_axis_tready = (state_q == ST_IDLE);
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tvalid = m_tvalid_q;

  // Datapath: current tap product and the input aligned to the accumulator's binary point.
  always_comb begin
    tap      = index_q[2:0] - 3'd1;  // index 1..8 maps to element 0..7
    prod     = a_sh_q[tap] * y_hist_q[tap];
    prod_ext = {{(acc_width-iw-cw){prod[iw+cw-1]}}, prod};
    x_ext    = {{(acc_width-iw){s_axis_tdata[iw-1]}}, s_axis_tdata} << cdw;
  end

  // Narrow acc >>> cdw (floor) to the output width.
`ifdef AXIS_IIR_INV8_SAT_EN
  always_comb begin
    y_narrow = acc_q[cdw +: iw];
    // Bits above the output sign must all match it, otherwise clamp by the acc sign.
    if (!((&acc_q[acc_width-1:cdw+iw-1]) || !(|acc_q[acc_width-1:cdw+iw-1])))
      y_narrow = acc_q[acc_width-1] ? {1'b1, {(iw-1){1'b0}}} : {1'b0, {(iw-1){1'b1}}};
  end
`else
  always_comb begin
    y_narrow = acc_q[cdw +: iw];
  end
`endif

  // Next-state and datapath control for IDLE -> MAC -> RESULT -> OUT.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    acc_d      = acc_q;
    index_d    = index_q;
    a_sh_d     = a_sh_q;
    y_hist_d   = y_hist_q;
    last_d     = last_q;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    m_tvalid_d = m_tvalid_q;
    case (state_q)
      ST_IDLE: begin
        if (s_axis_tvalid) begin
          acc_d   = x_ext;
          a_sh_d  = '{a1, a2, a3, a4, a5, a6, a7, a8};
          last_d  = s_axis_tlast;
          index_d = 4'd1;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d   = acc_q - prod_ext;
        index_d = index_q + 4'd1;
        if (index_q == 4'd8) state_d = ST_RESULT;
      end
      ST_RESULT: begin
        m_tdata_d   = y_narrow;
        m_tlast_d   = last_q;
        m_tvalid_d  = 1'b1;
        y_hist_d[0] = y_narrow;
        for (int k = 1; k < 8; k++) y_hist_d[k] = y_hist_q[k-1];
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (m_axis_tready) begin
          m_tvalid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the y history is part of the filter state, so it is reset like any other register.
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      index_q    <= '0;
      a_sh_q     <= '{default: '0};
      y_hist_q   <= '{default: '0};
      last_q     <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tvalid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from pre-edge values.
      state_q    <= state_d;
      acc_q      <= acc_d;
      index_q    <= index_d;
      a_sh_q     <= a_sh_d;
      y_hist_q   <= y_hist_d;
      last_q     <= last_d;
      m_tdata_q  <= m_tdata_d;
      m_tlast_q  <= m_tlast_d;
      m_tvalid_q <= m_tvalid_d;
    end
  end

endmodule
